tile_gpu: RTL and testbench

Parametrised tile-based VGA video generator, the next generation of the system's display block. It produces hs, vs and an 8-bit colour stream from four on-chip stores: a tile map, a per-cell palette select, a 4-bit tile pattern store and a colour palette table. It adds frame-synchronised hardware scrolling and a fully synchronous CPU write port. It sits on the CPU data/address bus as a write-only peripheral and drives the VGA DAC directly.

---
 rtl/tile_gpu_pkg.sv | 46 ++++
 rtl/tile_gpu_vga_timing.sv | 74 +++++++
 rtl/tile_gpu.sv | 215 +++++++++++++++++++++
 tb/tb_tile_gpu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tile_gpu_pkg.sv
// tile_gpu_pkg: shared constants and types for the tile_gpu display block.
//   BLANK_COLOR    colour driven outside the active area
//   REG_*          bus_addr[11:8] region codes of the write-only register map
//   DEF_*          default VGA timing and tile/map geometry
//   cidx_t         4-bit colour index (16 colours per palette)
//   pal_sel_t      palette select for the default palette count
//   vid_ctl_t      sync/blank/active bundle carried down the pixel pipeline
package tile_gpu_pkg;

   localparam logic [7:0] BLANK_COLOR = 8'b1111_1000;

   localparam logic [3:0] REG_PAL      = 4'hF;
   localparam logic [3:0] REG_HELPER   = 4'hE;
   localparam logic [3:0] REG_MAP_TILE = 4'hD;
   localparam logic [3:0] REG_MAP_PAL  = 4'hC;
   localparam logic [3:0] REG_PATTERN  = 4'hB;
   localparam logic [3:0] REG_SCROLL   = 4'hA;

   localparam int DEF_H_ACTIVE  = 800;
   localparam int DEF_H_FRONT   = 24;
   localparam int DEF_H_SYNC    = 72;
   localparam int DEF_H_BACK    = 128;
   localparam int DEF_V_ACTIVE  = 600;
   localparam int DEF_V_FRONT   = 1;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 22;
   localparam int DEF_TILE_LOG2 = 2;
   localparam int DEF_MAP_LOG2  = 6;
   localparam int DEF_NUM_TILES = 16;
   localparam int DEF_NUM_PAL   = 4;

   localparam int PIPE_STAGES = 3;

   typedef logic [3:0] cidx_t;
   typedef logic [$clog2(DEF_NUM_PAL)-1:0] pal_sel_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic vblank;
      logic active;
   } vid_ctl_t;

   localparam vid_ctl_t CTL_IDLE = '{hs: 1'b0, vs: 1'b0, vblank: 1'b1, active: 1'b0};

endpackage

// File: rtl/tile_gpu_vga_timing.sv
// vga_timing: horizontal/vertical raster counters for tile_gpu.
// Each axis runs front porch, sync, back porch, then active.
//   clk, reset        pixel clock, asynchronous active-high reset
//   h, v              current raster position
//   hs, vs            raw active-high syncs
//   active            h and v both inside the visible area
//   vblank            current line is outside the visible area
//   frame_sync_start  one-clock pulse on the first clock of vertical sync
module vga_timing
   import tile_gpu_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int H_W      = $clog2(H_FRONT + H_SYNC + H_BACK + H_ACTIVE),
   parameter int V_W      = $clog2(V_FRONT + V_SYNC + V_BACK + V_ACTIVE)
) (
   input  logic           clk,
   input  logic           reset,
   output logic [H_W-1:0] h,
   output logic [V_W-1:0] v,
   output logic           hs,
   output logic           vs,
   output logic           active,
   output logic           vblank,
   output logic           frame_sync_start
);

   localparam int H_TOTAL = H_FRONT + H_SYNC + H_BACK + H_ACTIVE;
   localparam int V_TOTAL = V_FRONT + V_SYNC + V_BACK + V_ACTIVE;
   localparam int H_START = H_FRONT + H_SYNC + H_BACK;
   localparam int V_START = V_FRONT + V_SYNC + V_BACK;

   logic [H_W-1:0] h_q, h_d;
   logic [V_W-1:0] v_q, v_d;
   logic           v_act;

   always_comb begin
      h_d = h_q + H_W'(1);
      v_d = v_q;
      if (h_q == H_W'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + V_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   always_comb begin
      v_act            = (v_q >= V_W'(V_START));
      hs               = (h_q >= H_W'(H_FRONT)) && (h_q < H_W'(H_FRONT + H_SYNC));
      vs               = (v_q >= V_W'(V_FRONT)) && (v_q < V_W'(V_FRONT + V_SYNC));
      active           = v_act && (h_q >= H_W'(H_START));
      vblank           = !v_act;
      frame_sync_start = (h_q == '0) && (v_q == V_W'(V_FRONT));
   end

   assign h = h_q;
   assign v = v_q;

endmodule

// File: rtl/tile_gpu.sv
// tile_gpu: tile-based VGA generator with a write-only CPU register port.
// Stores: tile map, per-cell palette select, 4-bit tile patterns, palettes.
// Pipeline: S1 map lookup, S2 pattern lookup, S3 palette lookup -> color.
// Optional feature macro: TILE_GPU_SCROLL_EN (frame-synchronised scroll).
//   clk, reset      pixel clock, asynchronous active-high reset
//   bus_addr        12-bit register address, region in [11:8]
//   bus_wdata       8-bit write data
//   bus_we          single-cycle write strobe
//   hs, vs          active-high syncs, 3 clocks behind the counters
//   color           pixel colour, BLANK_COLOR outside the active area
//   vblank          output line is outside the active area
module tile_gpu
   import tile_gpu_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int TILE_LOG2 = DEF_TILE_LOG2,
   parameter int MAP_LOG2  = DEF_MAP_LOG2,
   parameter int NUM_TILES = DEF_NUM_TILES,
   parameter int NUM_PAL   = DEF_NUM_PAL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] bus_addr,
   input  logic [7:0]  bus_wdata,
   input  logic        bus_we,
   output logic        hs,
   output logic        vs,
   output logic [7:0]  color,
   output logic        vblank
);

   localparam int H_W     = $clog2(H_FRONT + H_SYNC + H_BACK + H_ACTIVE);
   localparam int V_W     = $clog2(V_FRONT + V_SYNC + V_BACK + V_ACTIVE);
   localparam int H_START = H_FRONT + H_SYNC + H_BACK;
   localparam int V_START = V_FRONT + V_SYNC + V_BACK;
   localparam int PX_W    = MAP_LOG2 + TILE_LOG2;   // map wraps at this width
   localparam int PIX_W   = 2 * TILE_LOG2;          // pixel index within a tile
   localparam int TILE_W  = $clog2(NUM_TILES);
   localparam int PAL_W   = $clog2(NUM_PAL);
   localparam int MAP_AW  = 2 * MAP_LOG2;
   localparam int PAT_AW  = TILE_W + PIX_W - 1;     // patterns stored two pixels per byte
   localparam int STAGES  = PIPE_STAGES;

   // ---------------------------------------------------------------- timing
   logic [H_W-1:0] tm_h;
   logic [V_W-1:0] tm_v;
   logic           tm_hs, tm_vs, tm_active, tm_vblank, tm_frame_start;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
      .H_W      (H_W),      .V_W     (V_W)
   ) u_timing (
      .clk              (clk),
      .reset            (reset),
      .h                (tm_h),
      .v                (tm_v),
      .hs               (tm_hs),
      .vs               (tm_vs),
      .active           (tm_active),
      .vblank           (tm_vblank),
      .frame_sync_start (tm_frame_start)
   );

   // ---------------------------------------------------------------- stores
   // No reset on the stores; contents are undefined until written.
   logic [TILE_W-1:0] map_tile_mem [1 << MAP_AW];
   logic [PAL_W-1:0]  map_pal_mem  [1 << MAP_AW];
   logic [7:0]        pat_mem      [1 << PAT_AW];
   logic [7:0]        pal_mem      [NUM_PAL * 16];

   // ---------------------------------------------------------------- decode
   logic [3:0]        region;
   logic              pal_we, tile_we, mpal_we, pat_we;
   logic [MAP_AW-1:0] map_waddr;
   logic [PAT_AW-1:0] pat_waddr;
   logic [7:0]        helper_q, helper_d;

   always_comb begin
      region    = bus_addr[11:8];
      pal_we    = bus_we && (region == REG_PAL) && (int'(bus_addr[7:4]) < NUM_PAL);
      tile_we   = bus_we && (region == REG_MAP_TILE);
      mpal_we   = bus_we && (region == REG_MAP_PAL);
      pat_we    = bus_we && (region == REG_PATTERN);
      map_waddr = {helper_q[MAP_LOG2-1:0], bus_addr[MAP_LOG2-1:0]};
      pat_waddr = {helper_q[TILE_W-1:0], bus_addr[PIX_W-2:0]};
      helper_d  = (bus_we && (region == REG_HELPER)) ? bus_wdata : helper_q;
   end

   // Reads are combinational and registered by the pipeline, so a write on
   // this edge is seen by fetches from the next cycle on.
   always_ff @(posedge clk) begin
      if (pal_we)  pal_mem[bus_addr[PAL_W+3:0]] <= bus_wdata;
      if (tile_we) map_tile_mem[map_waddr]      <= bus_wdata[TILE_W-1:0];
      if (mpal_we) map_pal_mem[map_waddr]       <= bus_wdata[PAL_W-1:0];
      if (pat_we)  pat_mem[pat_waddr]           <= bus_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) helper_q <= '0;
      else       helper_q <= helper_d;
   end

   // ---------------------------------------------------------------- scroll
   logic [PX_W-1:0] scroll_x, scroll_y;
   logic            unused_bits;

`ifdef TILE_GPU_SCROLL_EN
   logic [PX_W-1:0] sx_pend_q, sx_pend_d, sy_pend_q, sy_pend_d;
   logic [PX_W-1:0] sx_q, sx_d, sy_q, sy_d;

   always_comb begin
      sx_pend_d = sx_pend_q;
      sy_pend_d = sy_pend_q;
      if (bus_we && (region == REG_SCROLL)) begin
         if (bus_addr[0]) sy_pend_d = PX_W'(bus_wdata);
         else             sx_pend_d = PX_W'(bus_wdata);
      end
      // Live offsets only move during vertical sync, never mid-frame.
      sx_d = tm_frame_start ? sx_pend_q : sx_q;
      sy_d = tm_frame_start ? sy_pend_q : sy_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sx_pend_q <= '0;
         sy_pend_q <= '0;
         sx_q      <= '0;
         sy_q      <= '0;
      end else begin
         sx_pend_q <= sx_pend_d;
         sy_pend_q <= sy_pend_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
      end
   end

   assign scroll_x    = sx_q;
   assign scroll_y    = sy_q;
   assign unused_bits = ^{helper_q};
`else
   assign scroll_x    = '0;
   assign scroll_y    = '0;
   assign unused_bits = ^{helper_q, tm_frame_start};
`endif

   // ---------------------------------------------------------------- pipeline
   logic [PX_W-1:0]   px, py;
   logic [TILE_W-1:0] s1_tile_q, s1_tile_d;
   logic [PAL_W-1:0]  s1_pal_q, s1_pal_d, s2_pal_q, s2_pal_d;
   logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;
   logic [7:0]        pat_byte;
   cidx_t             s2_cidx_q, s2_cidx_d;
   logic [7:0]        color_q, color_d;
   vid_ctl_t          ctl_raw;
   vid_ctl_t [STAGES:1] ctl_pipe_q, ctl_pipe_d;

   always_comb begin
      // Modular arithmetic at PX_W bits gives map wrap for free.
      px = PX_W'(tm_h) - PX_W'(H_START) + scroll_x;
      py = PX_W'(tm_v) - PX_W'(V_START) + scroll_y;

      // S1: map lookup
      s1_tile_d = map_tile_mem[{py[PX_W-1:TILE_LOG2], px[PX_W-1:TILE_LOG2]}];
      s1_pal_d  = map_pal_mem [{py[PX_W-1:TILE_LOG2], px[PX_W-1:TILE_LOG2]}];
      s1_pix_d  = {py[TILE_LOG2-1:0], px[TILE_LOG2-1:0]};

      // S2: pattern lookup; even pixel in the high nibble
      pat_byte  = pat_mem[{s1_tile_q, s1_pix_q[PIX_W-1:1]}];
      s2_cidx_d = s1_pix_q[0] ? pat_byte[3:0] : pat_byte[7:4];
      s2_pal_d  = s1_pal_q;

      // S3: palette lookup, blanked outside the active area
      color_d = ctl_pipe_q[STAGES-1].active ? pal_mem[{s2_pal_q, s2_cidx_q}] : BLANK_COLOR;

      ctl_raw.hs     = tm_hs;
      ctl_raw.vs     = tm_vs;
      ctl_raw.vblank = tm_vblank;
      ctl_raw.active = tm_active;
      ctl_pipe_d     = {ctl_pipe_q[STAGES-1:1], ctl_raw};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_tile_q  <= '0;
         s1_pal_q   <= '0;
         s1_pix_q   <= '0;
         s2_cidx_q  <= '0;
         s2_pal_q   <= '0;
         color_q    <= BLANK_COLOR;
         ctl_pipe_q <= {STAGES{CTL_IDLE}};
      end else begin
         s1_tile_q  <= s1_tile_d;
         s1_pal_q   <= s1_pal_d;
         s1_pix_q   <= s1_pix_d;
         s2_cidx_q  <= s2_cidx_d;
         s2_pal_q   <= s2_pal_d;
         color_q    <= color_d;
         ctl_pipe_q <= ctl_pipe_d;
      end
   end

   assign hs     = ctl_pipe_q[STAGES].hs;
   assign vs     = ctl_pipe_q[STAGES].vs;
   assign vblank = ctl_pipe_q[STAGES].vblank;
   assign color  = color_q;

endmodule

// File: tb/tb_tile_gpu.sv
// tb_tile_gpu: directed bench for tile_gpu. The vertical timing is shortened
// (5 blanking lines, 8 active lines) so several frames fit in a short run;
// horizontal timing keeps the default 1024-clock line.
module tb_tile_gpu;

   localparam int HF = 24, HS = 72, HB = 128, HA = 800;
   localparam int VF = 1,  VS = 2,  VB = 2,   VA = 8;
   localparam int HT = HF + HS + HB + HA;
   localparam int VT = VF + VS + VB + VA;
   localparam int HST = HF + HS + HB;
   localparam int VST = VF + VS + VB;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] bus_addr = '0;
   logic [7:0]  bus_wdata = '0;
   logic        bus_we = 1'b0;
   logic        hs, vs, vblank;
   logic [7:0]  color;

   int n_cmp = 0;
   int n_err = 0;

   tile_gpu #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .hs        (hs),
      .vs        (vs),
      .color     (color),
      .vblank    (vblank)
   );

   always #5 clk = ~clk;

   // Reference raster position: the counter value the design holds this cycle.
   int tb_h, tb_v;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         tb_h <= 0;
         tb_v <= 0;
      end else if (tb_h == HT - 1) begin
         tb_h <= 0;
         tb_v <= (tb_v == VT - 1) ? 0 : tb_v + 1;
      end else begin
         tb_h <= tb_h + 1;
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int h, input int v);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(tb_h == h && tb_v == v) && n < 20000);
      if (n >= 20000) begin
         n_cmp++;
         n_err++;
         $display("FAIL goto_timeout: at %0d/%0d expected %0d/%0d", tb_h, tb_v, h, v);
      end
   endtask

   // Park where the outputs reflect raster position (h,v).
   task automatic see(input int h, input int v);
      int th = h + LAT;
      int tv = v;
      if (th >= HT) begin
         th = th - HT;
         tv = (v + 1) % VT;
      end
      goto(th, tv);
   endtask

   task automatic pix(input int x, input int v, input logic [7:0] exp, input string tag);
      see(HST + x, v);
      chk(tag, color, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [7:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = 1'b1;
      @(posedge clk); #1;
      bus_we    = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_hs"},     hs,     8'h00);
      chk({tag, "_vs"},     vs,     8'h00);
      chk({tag, "_color"},  color,  8'hF8);
      chk({tag, "_vblank"}, vblank, 8'h01);
   endtask

   initial begin
      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      reset = 1'b0;

      // ---- line 0: hs window and blank colour
      see(23, 0);  chk("hs_h23", hs, 8'h00);
      see(24, 0);  chk("hs_h24", hs, 8'h01);
                   chk("blank_l0", color, 8'hF8);
                   chk("vblank_l0", vblank, 8'h01);
      see(95, 0);  chk("hs_h95", hs, 8'h01);
      see(96, 0);  chk("hs_h96", hs, 8'h00);

      // ---- vs on lines 1..2 only
      see(HT - 1, 0); chk("vs_end_l0", vs, 8'h00);
      see(0, 1);      chk("vs_start_l1", vs, 8'h01);
      see(HT - 1, 2); chk("vs_end_l2", vs, 8'h01);
      see(0, 3);      chk("vs_start_l3", vs, 8'h00);

      // ---- load stores during vertical back porch
      wr(12'hF12, 8'h5A);   // palette[1][2]
      wr(12'hF10, 8'h11);   // palette[1][0]
      wr(12'hF11, 8'h77);   // palette[1][1]
      wr(12'hF27, 8'hC3);   // palette[2][7]
      wr(12'hF39, 8'hE7);   // palette[3][9]
      wr(12'hE00, 8'h00);   // helper = row 0
      wr(12'hD00, 8'h03);   // map_tile[0][0]  = 3
      wr(12'hC00, 8'h01);   // map_pal[0][0]   = 1
      wr(12'hD3F, 8'h05);   // map_tile[0][63] = 5
      wr(12'hC3F, 8'h02);   // map_pal[0][63]  = 2
      wr(12'hD01, 8'h06);   // map_tile[0][1]  = 6
      wr(12'hC01, 8'h03);   // map_pal[0][1]   = 3
      wr(12'hE00, 8'h03);   // helper = tile 3
      wr(12'hB00, 8'h20);   // pixels 0,1 = 2,0
      for (int k = 1; k < 8; k++) wr(12'hB00 | 12'(k), 8'h11);
      wr(12'hE00, 8'h05);   // helper = tile 5
      wr(12'hB01, 8'h07);   // pixels 2,3 = 0,7
      wr(12'hE00, 8'h06);   // helper = tile 6
      wr(12'hB00, 8'h90);   // pixels 0,1 = 9,0

      // ---- first active line
      see(24, VST);    chk("hs_active_line", hs, 8'h01);
      see(HST - 1, VST); chk("blank_back_porch", color, 8'hF8);
      pix(0, VST, 8'h5A, "px0");
      chk("vblank_active", vblank, 8'h00);
      pix(1, VST, 8'h11, "px1");
      pix(2, VST, 8'h77, "px2");
      pix(255, VST, 8'hC3, "px255_col63");
      pix(256, VST, 8'h5A, "px256_wrap");
      pix(257, VST, 8'h11, "px257_wrap");
      see(0, VST + 1); chk("blank_front_porch", color, 8'hF8);

      // ---- scroll write mid-frame must not disturb this frame
      goto(100, VST + 3);
      wr(12'hA00, 8'h04);
      pix(0, VST + 3, 8'h77, "midframe_px0");
      pix(1, VST + 3, 8'h77, "midframe_px1");

      // ---- frame boundary
      see(HT - 1, VT - 1); chk("vblank_last_line", vblank, 8'h00);
      see(0, 0);           chk("vblank_wrap", vblank, 8'h01);

`ifdef TILE_GPU_SCROLL_EN
      pix(0, VST, 8'hE7, "scroll_next_frame");
`else
      pix(0, VST, 8'h5A, "scroll_next_frame");
`endif

      // ---- reset mid-frame
      goto(500, VST + 3);
      reset = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_hold_color", color, 8'hF8);
      reset = 1'b0;

      see(HT - 1, 0); chk("rst_vs_end_l0", vs, 8'h00);
      see(0, 1);      chk("rst_vs_start_l1", vs, 8'h01);
      see(HT - 1, 2); chk("rst_vs_end_l2", vs, 8'h01);
      see(0, 3);      chk("rst_vs_start_l3", vs, 8'h00);

      // ---- unmapped region write is ignored; stores survive reset
      wr(12'h07F, 8'h99);
      pix(0, VST, 8'h5A, "post_rst_px0");
      pix(1, VST, 8'h11, "post_rst_px1");
      pix(2, VST, 8'h77, "post_rst_px2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
